qe_sample_sequencer: RTL and testbench
======================================

# qe_sample_sequencer

Periodic sampling scheduler for a bank of quadrature-encoder channels. A programmable period timer triggers a sampling frame; the sequencer then visits each channel round-robin, snapshots its 32-bit pulse count, computes the signed count change since the previous frame, and publishes per-channel snapshot and delta registers with a valid strobe. It sits between the QE channel count outputs and the motion-control register map, giving the uP time-coherent position and velocity samples with no per-channel software polling.

## Interface
- NOS_CHANNELS, 4, number of QE channels sequenced (1..8)
- DELTA_LIMIT, 32'h0000_FFFF, saturation magnitude for delta (used only with QE_SAMPLE_DELTA_SAT_EN)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- enable  in  1  sequencer run enable
- sample_period  in  32  clocks between frame ticks; 0 = timer stopped
- count_in  in  NOS_CHANNELS*32  channel counts, channel k at bits [32k+31:32k]
- overrun_clear  in  1  single-cycle clear of overrun flag
- snapshot  out  NOS_CHANNELS*32  latched count per channel
- delta  out  NOS_CHANNELS*32  signed count change per channel
- sample_valid  out  NOS_CHANNELS  one-cycle pulse when channel k's registers update
- frame_done  out  1  one-cycle pulse after last channel stored
- busy  out  1  high while a frame is in progress
- overrun  out  1  sticky: tick arrived while busy

## Operation
- All outputs reset to 0; internal prev-count array 0; first_frame flag = 1.
- Period timer: on enable rising or sample_period change, loads sample_period; decrements each clk; at 1 issues tick and reloads. enable=0 or sample_period=0 holds timer at load value, no ticks.
- FSM states: IDLE, WAIT_TICK, LATCH, STORE, NEXT, DONE.
- IDLE -> WAIT_TICK when enable=1. Any state -> IDLE when enable=0 (frame abandoned, no further valid pulses, snapshot/delta keep last values, first_frame set to 1).
- WAIT_TICK -> LATCH on tick; channel index ch=0; busy=1.
- LATCH: temp <= count_in[ch]. -> STORE.
- STORE: snapshot[ch] <= temp; delta[ch] <= first_frame ? 0 : temp - prev[ch] (32-bit modulo, interpreted signed); prev[ch] <= temp; sample_valid[ch] pulses. -> NEXT.
- NEXT: if ch == NOS_CHANNELS-1 -> DONE else ch++ -> LATCH.
- DONE: frame_done pulses, first_frame <= 0, busy <= 0. -> WAIT_TICK.
- Tick while busy: dropped, overrun <= 1. overrun_clear and simultaneous new overrun in same cycle: set wins.
- Wrap-around: count 32'hFFFF_FFFE -> 32'h0000_0001 yields delta +3.

## Timing
- Tick to first sample_valid: 2 cycles (LATCH, STORE registered output on 3rd edge).
- Channel k sampled 3k+1 cycles after tick; frame_done 3*NOS_CHANNELS+1 cycles after tick.
- Intra-frame skew between channels: 3 cycles per channel (accepted; documented).
- sample_period must exceed 3*NOS_CHANNELS+1 to avoid overrun.
- busy asserts the cycle after tick, deasserts with frame_done.

## Configuration
- QE_SAMPLE_DELTA_SAT_EN defined: delta clamped to [-DELTA_LIMIT, +DELTA_LIMIT] after subtraction; prev still updated with raw count.
- Undefined: delta is raw modulo-2^32 difference; DELTA_LIMIT unused.

## Structure
- types package: seq_state_t enum (IDLE, WAIT_TICK, LATCH, STORE, NEXT, DONE).
- global_constants.sv: default NOS_QE_CHANNELS, default DELTA_LIMIT.
- One sub-module: sample_tick_timer (load/decrement/reload, tick output, enable and zero-period hold).

## Test plan
- NOS_CHANNELS=4, period=20, counts {10,20,30,40} constant: first frame delta all 0, snapshots match, sample_valid bits 0..3 at tick+3,+6,+9,+12 (offsets 1,4,7,10 after first), frame_done at tick+13.
- Second frame with counts {15,20,25,-1(32'hFFFF_FFFF)... from 40}: deltas {+5,0,-5,-41}.
- Wrap: ch0 32'hFFFF_FFFE then 32'h0000_0001 -> delta 3; with QE_SAMPLE_DELTA_SAT_EN, DELTA_LIMIT=100 and jump +500 -> delta 100.
- period=8 (< 13): overrun sets on second tick, stays set; overrun_clear pulse clears; same-cycle clear and tick-while-busy -> stays 1.
- enable drop during STORE of ch1: FSM to IDLE, no further sample_valid, no frame_done; re-enable -> next frame delta 0 (first_frame).
- Async reset mid-frame: all outputs 0 immediately, busy 0, first frame after release reports delta 0.

Source files
------------

// File: rtl/qe_sample_sequencer_pkg.sv
// Shared types and defaults for the QE sample sequencer slice.
package qe_sample_sequencer_pkg;

    localparam int          NOS_QE_CHANNELS     = 4;
    localparam logic [31:0] DEFAULT_DELTA_LIMIT = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        LATCH,
        STORE,
        NEXT,
        DONE
    } seq_state_t;

    // Clamp a two's-complement delta to [-limit, +limit]; limit is a magnitude.
    function automatic logic [31:0] clamp_delta(input logic [31:0] raw, input logic [31:0] limit);
        logic signed [32:0] r;
        logic signed [32:0] l;
        r = {raw[31], raw};
        l = {1'b0, limit};
        if (r > l)
            return limit;
        else if (r < (33'sd0 - l))
            return ~limit + 32'd1;
        else
            return raw;
    endfunction

endpackage

// File: rtl/qe_sample_sequencer_if.sv
// Control inputs and published sample registers of the QE sample sequencer.
interface qe_sample_sequencer_if
    import qe_sample_sequencer_pkg::*;
#(
    parameter int NOS_CHANNELS = NOS_QE_CHANNELS
);
    logic                        enable;
    logic [31:0]                 sample_period;
    logic [NOS_CHANNELS*32-1:0]  count_in;
    logic                        overrun_clear;
    logic [NOS_CHANNELS*32-1:0]  snapshot;
    logic [NOS_CHANNELS*32-1:0]  delta;
    logic [NOS_CHANNELS-1:0]     sample_valid;
    logic                        frame_done;
    logic                        busy;
    logic                        overrun;

    modport master (
        output enable, sample_period, count_in, overrun_clear,
        input  snapshot, delta, sample_valid, frame_done, busy, overrun
    );

    modport slave (
        input  enable, sample_period, count_in, overrun_clear,
        output snapshot, delta, sample_valid, frame_done, busy, overrun
    );
endinterface

// File: rtl/qe_sample_sequencer_sample_tick_timer.sv
// Period down-counter: reloads on enable rise or period change, ticks at terminal count 1.
module sample_tick_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] sample_period,
    output logic        tick
);
    logic [31:0] count;
    logic [31:0] period_q;
    logic        enable_q;
    logic        run;
    logic        load;

    assign run  = enable && (sample_period != 32'd0);
    assign load = (enable && !enable_q) || (sample_period != period_q);
    assign tick = run && !load && (count == 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            period_q <= '0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            period_q <= sample_period;
            // Stopped timer parks at the load value so a restart counts a full period.
            if (!run || load || (count == 32'd1))
                count <= sample_period;
            else
                count <= count - 32'd1;
        end
    end
endmodule

// File: rtl/qe_sample_sequencer.sv
// Frame sequencer: snapshots each QE channel count and publishes per-channel deltas.
// Build option QE_SAMPLE_DELTA_SAT_EN clamps each delta to +/-DELTA_LIMIT.
//   state     | meaning
//   IDLE      | disabled; next frame reports zero delta
//   WAIT_TICK | armed, waiting for period tick
//   LATCH     | capture count_in of channel ch
//   STORE     | publish snapshot/delta of channel ch
//   NEXT      | advance ch or close the frame
//   DONE      | frame_done pulse; a tick landing here starts the next frame
module qe_sample_sequencer
    import qe_sample_sequencer_pkg::*;
#(
    parameter int          NOS_CHANNELS = NOS_QE_CHANNELS,
    parameter logic [31:0] DELTA_LIMIT  = DEFAULT_DELTA_LIMIT
) (
    input logic                  clk,
    input logic                  reset,
    qe_sample_sequencer_if.slave bus
);
    localparam int CH_W = (NOS_CHANNELS > 1) ? $clog2(NOS_CHANNELS) : 1;

    seq_state_t              state;
    seq_state_t              state_nxt;
    logic                    tick;
    logic [CH_W-1:0]         ch;
    logic                    last_ch;
    logic [31:0]             temp;
    logic [31:0]             delta_raw;
    logic [31:0]             delta_new;
    logic [31:0]             count_ch [NOS_CHANNELS];
    logic [31:0]             prev     [NOS_CHANNELS];
    logic [31:0]             snap_r   [NOS_CHANNELS];
    logic [31:0]             delta_r  [NOS_CHANNELS];
    logic [NOS_CHANNELS-1:0] valid_r;
    logic                    first_frame;
    logic                    busy_r;
    logic                    done_r;
    logic                    overrun_r;

    sample_tick_timer u_timer (
        .clk           (clk),
        .reset         (reset),
        .enable        (bus.enable),
        .sample_period (bus.sample_period),
        .tick          (tick)
    );

    for (genvar k = 0; k < NOS_CHANNELS; k++) begin : g_ch
        assign count_ch[k]                = bus.count_in[32*k +: 32];
        assign bus.snapshot[32*k +: 32]   = snap_r[k];
        assign bus.delta[32*k +: 32]      = delta_r[k];
    end

    assign bus.sample_valid = valid_r;
    assign bus.frame_done   = done_r;
    assign bus.busy         = busy_r;
    assign bus.overrun      = overrun_r;

    assign last_ch   = (ch == CH_W'(NOS_CHANNELS - 1));
    assign delta_raw = temp - prev[ch];

`ifdef QE_SAMPLE_DELTA_SAT_EN
    assign delta_new = first_frame ? 32'd0 : clamp_delta(delta_raw, DELTA_LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^DELTA_LIMIT;
    assign delta_new    = first_frame ? 32'd0 : delta_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_TICK;
                WAIT_TICK: if (tick) state_nxt = LATCH;
                LATCH:     state_nxt = STORE;
                STORE:     state_nxt = NEXT;
                NEXT:      state_nxt = last_ch ? DONE : LATCH;
                DONE:      state_nxt = tick ? LATCH : WAIT_TICK;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch          <= '0;
            temp        <= '0;
            valid_r     <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            first_frame <= 1'b1;
            for (int k = 0; k < NOS_CHANNELS; k++) begin
                prev[k]    <= '0;
                snap_r[k]  <= '0;
                delta_r[k] <= '0;
            end
        end else begin
            valid_r <= '0;
            done_r  <= 1'b0;

            if (tick && busy_r)
                overrun_r <= 1'b1;
            else if (bus.overrun_clear)
                overrun_r <= 1'b0;

            // Dropping enable abandons the frame; published registers hold their last values.
            if (!bus.enable) begin
                busy_r      <= 1'b0;
                first_frame <= 1'b1;
            end else begin
                case (state)
                    WAIT_TICK, DONE: begin
                        if (tick) begin
                            ch     <= '0;
                            busy_r <= 1'b1;
                        end
                    end
                    LATCH: temp <= count_ch[ch];
                    STORE: begin
                        snap_r[ch]  <= temp;
                        delta_r[ch] <= delta_new;
                        prev[ch]    <= temp;
                        valid_r[ch] <= 1'b1;
                    end
                    NEXT: begin
                        if (last_ch) begin
                            done_r      <= 1'b1;
                            first_frame <= 1'b0;
                            busy_r      <= 1'b0;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qe_sample_sequencer.sv
// Self-checking bench for qe_sample_sequencer: table frames, random frames, corner sequences.
module tb_qe_sample_sequencer;
    localparam int          N   = 4;
    localparam logic [31:0] LIM = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   next_tick = 0;
    int   period    = 20;

    logic [31:0] prev_m  [N];
    bit          first_m;
    logic [31:0] cur_cnt [N];
    logic [31:0] cur_dlt [N];

    typedef struct {
        logic [31:0] cnt [N];
        logic [31:0] dlt [N];
    } vec_t;
    vec_t vecs [5];

    qe_sample_sequencer_if #(.NOS_CHANNELS(N)) bus ();

    qe_sample_sequencer #(.NOS_CHANNELS(N), .DELTA_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit at cyc %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Signed count change between frames, 32-bit modulo, optionally saturated.
    function automatic logic [31:0] model_delta(input logic [31:0] c, input logic [31:0] p, input bit first);
        longint d;
        if (first) return 32'd0;
        d = longint'($signed(c - p));
`ifdef QE_SAMPLE_DELTA_SAT_EN
        if (d > longint'(LIM)) d = longint'(LIM);
        else if (d < -longint'(LIM)) d = -longint'(LIM);
`endif
        return d[31:0];
    endfunction

    task automatic model_reset();
        first_m = 1'b1;
        for (int k = 0; k < N; k++) prev_m[k] = '0;
    endtask

    task automatic start(input int p);
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.overrun_clear = 1'b0;
        period = p;
        bus.sample_period = 32'(p);
        step();
        step();
        reset = 1'b1;
        bus.enable = 1'b1;
        cyc = 0;
        next_tick = p;
        model_reset();
    endtask

    task automatic random_counts();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0)
                cur_cnt[k] = $urandom;
            else
                cur_cnt[k] = prev_m[k] + 32'($urandom_range(0, 2000)) - 32'd1000;
            cur_dlt[k] = model_delta(cur_cnt[k], prev_m[k], first_m);
        end
    endtask

    task automatic apply_counts();
        bus.count_in = {cur_cnt[3], cur_cnt[2], cur_cnt[1], cur_cnt[0]};
    endtask

    // Runs one full frame whose tick lands in cycle next_tick, checking every cycle.
    task automatic do_frame();
        logic [N-1:0] ev;
        apply_counts();
        while (cyc < next_tick) begin
            step();
            chk("idle_valid", 32'(bus.sample_valid), 32'd0);
        end
        for (int off = 1; off <= 3*N+1; off++) begin
            step();
            ev = '0;
            if ((off % 3 == 0) && (off <= 3*N)) ev[off/3 - 1] = 1'b1;
            chk("sample_valid", 32'(bus.sample_valid), 32'(ev));
            chk("frame_done", 32'(bus.frame_done), (off == 3*N+1) ? 32'd1 : 32'd0);
            chk("busy", 32'(bus.busy), (off <= 3*N) ? 32'd1 : 32'd0);
            for (int k = 0; k < N; k++) begin
                if (ev[k]) begin
                    chk("snapshot", bus.snapshot[32*k +: 32], cur_cnt[k]);
                    chk("delta", bus.delta[32*k +: 32], cur_dlt[k]);
                end
            end
        end
        for (int k = 0; k < N; k++) prev_m[k] = cur_cnt[k];
        first_m = 1'b0;
        next_tick += period;
    endtask

    initial begin
        vecs[0].cnt = '{32'd10, 32'd20, 32'd30, 32'd40};
        vecs[0].dlt = '{32'd0, 32'd0, 32'd0, 32'd0};
        vecs[1].cnt = '{32'd15, 32'd20, 32'd25, 32'hFFFF_FFFF};
        vecs[1].dlt = '{32'd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFD7};
        vecs[2].cnt = '{32'hFFFF_FFFE, 32'd520, 32'd25, 32'hFFFF_FFFF};
        vecs[2].dlt = '{32'hFFFF_FFEF, 32'd500, 32'd0, 32'd0};
        vecs[3].cnt = '{32'h0000_0001, 32'h0002_0208, 32'hFFFD_0019, 32'h0000_0000};
`ifdef QE_SAMPLE_DELTA_SAT_EN
        vecs[3].dlt = '{32'd3, 32'h0000_FFFF, 32'hFFFF_0001, 32'd1};
`else
        vecs[3].dlt = '{32'd3, 32'h0002_0000, 32'hFFFD_0000, 32'd1};
`endif
        vecs[4].cnt = '{32'h0000_0001, 32'h0002_0208, 32'hFFFD_0019, 32'h0000_0000};
        vecs[4].dlt = '{32'd0, 32'd0, 32'd0, 32'd0};

        reset = 1'b0;
        bus.enable = 1'b0;
        bus.sample_period = 32'd20;
        bus.count_in = '0;
        bus.overrun_clear = 1'b0;
        step();
        step();
        chk("rst_snapshot", 32'(|bus.snapshot), 32'd0);
        chk("rst_delta", 32'(|bus.delta), 32'd0);
        chk("rst_valid", 32'(bus.sample_valid), 32'd0);
        chk("rst_done_busy_ovr", {29'd0, bus.frame_done, bus.busy, bus.overrun}, 32'd0);

        // Table-driven frames, then random frames against the model.
        start(20);
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < N; k++) begin
                cur_cnt[k] = vecs[f].cnt[k];
                cur_dlt[k] = vecs[f].dlt[k];
            end
            do_frame();
        end
        for (int f = 0; f < 6; f++) begin
            random_counts();
            do_frame();
        end

        // Enable dropped during STORE of channel 1.
        begin
            int t;
            t = next_tick;
            random_counts();
            apply_counts();
            while (cyc < t + 3) step();
            chk("drop_valid0", 32'(bus.sample_valid), 32'd1);
            chk("drop_delta0", bus.delta[31:0], cur_dlt[0]);
            prev_m[0] = cur_cnt[0];
            while (cyc < t + 5) step();
            bus.enable = 1'b0;
            step();
            chk("drop_busy", 32'(bus.busy), 32'd0);
            chk("drop_snap1_kept", bus.snapshot[63:32], prev_m[1]);
            while (cyc < t + 20) begin
                chk("drop_no_valid", 32'(bus.sample_valid), 32'd0);
                chk("drop_no_done", 32'(bus.frame_done), 32'd0);
                step();
            end
            first_m = 1'b1;
            bus.enable = 1'b1;
            next_tick = cyc + period;
            random_counts();
            do_frame();
            random_counts();
            do_frame();
        end

        // Asynchronous reset in the middle of a frame.
        random_counts();
        apply_counts();
        while (cyc < next_tick + 5) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_snapshot", 32'(|bus.snapshot), 32'd0);
        chk("arst_delta", 32'(|bus.delta), 32'd0);
        chk("arst_valid", 32'(bus.sample_valid), 32'd0);
        chk("arst_done_busy_ovr", {29'd0, bus.frame_done, bus.busy, bus.overrun}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        next_tick = period;
        model_reset();
        random_counts();
        do_frame();

        // Overrun: period 8 is shorter than a 4-channel frame.
        start(8);
        random_counts();
        apply_counts();
        while (cyc < 34) begin
            step();
            chk("overrun", 32'(bus.overrun), ((cyc >= 17 && cyc <= 24) || cyc >= 33) ? 32'd1 : 32'd0);
            if (cyc == 21) chk("ovr_frame_done", 32'(bus.frame_done), 32'd1);
            if (cyc == 27) chk("ovr_next_frame", 32'(bus.sample_valid), 32'd1);
            bus.overrun_clear = (cyc == 24 || cyc == 32);
        end
        bus.overrun_clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
